stream_downsize: RTL and testbench



---
 rtl/stream_pkg.sv | 16 +
 rtl/stream_prio_enc.sv | 21 ++
 rtl/stream_downsize.sv | 76 +++++++
 tb/tb_stream_downsize.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream width converters.
// Used by stream_downsize and its upsizing counterpart.
package stream_pkg;

   localparam int T_DATA_WIDTH_DEF = 8;
   localparam int T_DATA_RATIO_DEF = 16;
   localparam int IDX_W            = $clog2(T_DATA_RATIO_DEF);

   // Widest keep mask the helper below accepts; narrower masks are zero-extended.
   localparam int MASK_MAX = 64;

   function automatic logic onehot_or_zero(input logic [MASK_MAX-1:0] mask);
      return (mask & (mask - MASK_MAX'(1))) == '0;
   endfunction

endpackage

// File: rtl/stream_prio_enc.sv
// Lowest-set-bit priority encoder; purely combinational.
// idx_o is 0 when no bit is set (check any_o).
module stream_prio_enc #(
   parameter int N = 16,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  mask_i,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      idx_o = '0;
      any_o = |mask_i;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask_i[i]) idx_o = IW'(i);
      end
   end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits the kept words of each wide beat,
// one per cycle, lowest index first.
module stream_downsize
   import stream_pkg::*;
#(
   parameter int T_DATA_WIDTH = T_DATA_WIDTH_DEF,
   parameter int T_DATA_RATIO = T_DATA_RATIO_DEF
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i,
   input  logic [T_DATA_RATIO-1:0]                   s_keep_i,
   input  logic                                      s_last_i,
   input  logic                                      s_valid_i,
   output logic                                      s_ready_o,
   output logic [T_DATA_WIDTH-1:0]                   m_data_o,
   output logic                                      m_last_o,
   output logic                                      m_valid_o,
   input  logic                                      m_ready_i
);

   localparam int IW = $clog2(T_DATA_RATIO);

   logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] buf_q;
   logic [T_DATA_RATIO-1:0]                   rem_keep_q, rem_keep_d;
   logic                                      buf_last_q, buf_last_d;

   logic [IW-1:0] idx;
   logic          any;
   logic          single;
   logic          s_fire;
   logic          m_fire;

   stream_prio_enc #(.N(T_DATA_RATIO)) u_prio_enc (
      .mask_i (rem_keep_q),
      .idx_o  (idx),
      .any_o  (any)
   );

   assign single    = onehot_or_zero(MASK_MAX'(rem_keep_q));
   assign m_valid_o = any;
   assign m_data_o  = any ? buf_q[idx] : '0;
   assign m_last_o  = buf_last_q && any && single;

   // Refill is allowed while the final kept word is leaving, so beats chain without bubbles.
   assign s_ready_o = !any || (m_ready_i && single);
   assign s_fire    = s_valid_i && s_ready_o;
   assign m_fire    = any && m_ready_i;

   always_comb begin
      rem_keep_d = rem_keep_q;
      buf_last_d = buf_last_q;
      if (m_fire) rem_keep_d = rem_keep_q & ~(T_DATA_RATIO'(1) << idx);
      if (s_fire) begin
         rem_keep_d = s_keep_i;
         buf_last_d = s_last_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_keep_q <= '0;
         buf_last_q <= 1'b0;
      end else begin
         rem_keep_q <= rem_keep_d;
         buf_last_q <= buf_last_d;
      end
   end

   // NOTE: the data buffer is not reset; it is only observed through rem_keep_q, which is.
   always_ff @(posedge clk) begin
      if (s_fire) buf_q <= s_data_i;
   end

endmodule

// File: tb/tb_stream_downsize.sv
// Directed self-checking bench for stream_downsize at 4 words x 8 bits.
`timescale 1ns/1ps
module tb_stream_downsize;

   localparam int W = 8;
   localparam int R = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [R-1:0][W-1:0] s_data;
   logic [R-1:0]       s_keep;
   logic               s_last;
   logic               s_valid;
   logic               s_ready;
   logic [W-1:0]       m_data;
   logic               m_last;
   logic               m_valid;
   logic               m_ready;

   int checks = 0;
   int errors = 0;

   stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_data_i  (s_data),
      .s_keep_i  (s_keep),
      .s_last_i  (s_last),
      .s_valid_i (s_valid),
      .s_ready_o (s_ready),
      .m_data_o  (m_data),
      .m_last_o  (m_last),
      .m_valid_o (m_valid),
      .m_ready_i (m_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [W-1:0] d,
                             input logic l, input logic r);
      check({tag, ".valid"}, 32'(m_valid), 32'(v));
      check({tag, ".data"},  32'(m_data),  32'(d));
      check({tag, ".last"},  32'(m_last),  32'(l));
      check({tag, ".ready"}, 32'(s_ready), 32'(r));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [R-1:0][W-1:0] d, input logic [R-1:0] k, input logic l);
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      s_valid = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n   = 1'b0;
      s_data  = '0;
      s_keep  = '0;
      s_last  = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b1);

      // Full beat, no backpressure.
      offer({8'h03, 8'h02, 8'h01, 8'h00}, 4'b1111, 1'b1);
      tick();
      s_valid = 1'b0;
      expect_out("full.w0", 1'b1, 8'h00, 1'b0, 1'b0);
      tick();
      expect_out("full.w1", 1'b1, 8'h01, 1'b0, 1'b0);
      tick();
      expect_out("full.w2", 1'b1, 8'h02, 1'b0, 1'b0);
      tick();
      expect_out("full.w3", 1'b1, 8'h03, 1'b1, 1'b1);
      tick();
      expect_out("full.idle", 1'b0, 8'h00, 1'b0, 1'b1);

      // Sparse keep followed back-to-back by a single-word last beat.
      offer({8'h0D, 8'h0C, 8'h0B, 8'h0A}, 4'b1010, 1'b0);
      tick();
      offer({8'hFF, 8'hFF, 8'hFF, 8'h0E}, 4'b0001, 1'b1);
      expect_out("sparse.B", 1'b1, 8'h0B, 1'b0, 1'b0);
      tick();
      expect_out("sparse.D", 1'b1, 8'h0D, 1'b0, 1'b1);
      tick();
      s_valid = 1'b0;
      expect_out("sparse.E", 1'b1, 8'h0E, 1'b1, 1'b1);
      tick();
      expect_out("sparse.idle", 1'b0, 8'h00, 1'b0, 1'b1);

      // Backpressure holds word 0 stable.
      m_ready = 1'b0;
      offer({8'h44, 8'h33, 8'h22, 8'h11}, 4'b0111, 1'b0);
      tick();
      s_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         expect_out($sformatf("bp.hold%0d", i), 1'b1, 8'h11, 1'b0, 1'b0);
         tick();
      end
      m_ready = 1'b1;
      #1;
      expect_out("bp.w0", 1'b1, 8'h11, 1'b0, 1'b0);
      tick();
      expect_out("bp.w1", 1'b1, 8'h22, 1'b0, 1'b0);
      tick();
      expect_out("bp.w2", 1'b1, 8'h33, 1'b0, 1'b1);
      tick();
      expect_out("bp.idle", 1'b0, 8'h00, 1'b0, 1'b1);

      // keep=0 beat between two full beats is swallowed in one cycle.
      offer({8'h13, 8'h12, 8'h11, 8'h10}, 4'b1111, 1'b0);
      tick();
      offer({8'h99, 8'h98, 8'h97, 8'h96}, 4'b0000, 1'b0);
      expect_out("k0.a0", 1'b1, 8'h10, 1'b0, 1'b0);
      tick();
      expect_out("k0.a1", 1'b1, 8'h11, 1'b0, 1'b0);
      tick();
      expect_out("k0.a2", 1'b1, 8'h12, 1'b0, 1'b0);
      tick();
      expect_out("k0.a3", 1'b1, 8'h13, 1'b0, 1'b1);
      tick();
      expect_out("k0.drop", 1'b0, 8'h00, 1'b0, 1'b1);
      offer({8'h23, 8'h22, 8'h21, 8'h20}, 4'b1111, 1'b1);
      tick();
      s_valid = 1'b0;
      expect_out("k0.b0", 1'b1, 8'h20, 1'b0, 1'b0);
      tick();
      expect_out("k0.b1", 1'b1, 8'h21, 1'b0, 1'b0);
      tick();
      expect_out("k0.b2", 1'b1, 8'h22, 1'b0, 1'b0);
      tick();
      expect_out("k0.b3", 1'b1, 8'h23, 1'b1, 1'b1);
      tick();
      expect_out("k0.idle", 1'b0, 8'h00, 1'b0, 1'b1);

      // Asynchronous reset after two of four words.
      offer({8'h33, 8'h32, 8'h31, 8'h30}, 4'b1111, 1'b1);
      tick();
      s_valid = 1'b0;
      expect_out("rst.w0", 1'b1, 8'h30, 1'b0, 1'b0);
      tick();
      expect_out("rst.w1", 1'b1, 8'h31, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("rst.async", 1'b0, 8'h00, 1'b0, 1'b1);
      offer({8'h55, 8'h55, 8'h55, 8'h55}, 4'b1111, 1'b1);
      tick();
      s_valid = 1'b0;
      expect_out("rst.held", 1'b0, 8'h00, 1'b0, 1'b1);
      #2;
      rst_n = 1'b1;
      tick();
      expect_out("rst.release", 1'b0, 8'h00, 1'b0, 1'b1);
      offer({8'hEE, 8'hEE, 8'h41, 8'h40}, 4'b0011, 1'b1);
      tick();
      s_valid = 1'b0;
      expect_out("rst.n0", 1'b1, 8'h40, 1'b0, 1'b0);
      tick();
      expect_out("rst.n1", 1'b1, 8'h41, 1'b1, 1'b1);
      tick();
      expect_out("rst.idle", 1'b0, 8'h00, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
